// File: rtl/controlador_temporizador.sv
// controlador_temporizador: master-side controller for the R/G/B cycle timer.
// Loads per-colour cycle counts from the switches, strobes `enter` to start
// the timer, follows the timer's phase-done flags and drives a one-hot RGB LED.
// Optional feature macro: WATCHDOG_EN (per-phase timeout that sets o_error).
//
// Handshake: every input is a 1-cycle pulse sampled on the rising edge of
// i_clk. No back-pressure exists. Every output is a register, so its response
// to a pulse is visible one cycle after the edge that sampled the pulse.
module controlador_temporizador #(
  parameter int W         = 5,
  parameter int ENTER_LEN = 10,
  parameter int REPETIR   = 1,
  parameter int WD_LIM    = 40
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_dato,
  input  logic         i_cargar,
  input  logic         i_iniciar,
  input  logic         i_detener,
  input  logic [2:0]   i_flags,
  output logic [W-1:0] o_ciclos_r,
  output logic [W-1:0] o_ciclos_g,
  output logic [W-1:0] o_ciclos_b,
  output logic         o_enter,
  output logic [2:0]   o_led_rgb,
  output logic         o_ocupado,
  output logic         o_error,
  output logic [2:0]   o_estado
);

  typedef enum logic [2:0] {
    CARGA_R  = 3'd0,
    CARGA_G  = 3'd1,
    CARGA_B  = 3'd2,
    LISTO    = 3'd3,
    ARRANQUE = 3'd4,
    FASE_R   = 3'd5,
    FASE_G   = 3'd6,
    FASE_B   = 3'd7
  } estado_t;

  localparam int            EW        = (ENTER_LEN > 1) ? $clog2(ENTER_LEN) : 1;
  localparam logic [EW-1:0] ENTER_FIN = EW'(ENTER_LEN - 1);

  // Reject parameter values that would make the enter strobe or watchdog meaningless.
  if (ENTER_LEN < 1 || WD_LIM < 1) begin : g_param_err
    $error("controlador_temporizador: ENTER_LEN and WD_LIM must be >= 1");
  end

  estado_t       r_estado, w_estado_nxt;
  logic [EW-1:0] r_cnt_enter, w_cnt_enter_nxt;
  logic [W-1:0]  r_ciclos_r, r_ciclos_g, r_ciclos_b;
  logic [W-1:0]  w_ciclos_r_nxt, w_ciclos_g_nxt, w_ciclos_b_nxt;
  logic [W-1:0]  w_dato_clamp;
  logic          r_enter, r_ocupado;
  logic [2:0]    r_led_rgb;
  logic          w_enter_nxt, w_ocupado_nxt;
  logic [2:0]    w_led_nxt;
  logic          w_timeout;

  // A zero count would stall the timer, so it is stored as 1.
  assign w_dato_clamp = (i_dato == '0) ? W'(1) : i_dato;

`ifdef WATCHDOG_EN
  localparam int DW = $clog2(WD_LIM + 1);
  logic [DW-1:0] r_wd;
  logic          r_error;
  logic          w_en_fase;

  assign w_en_fase = (r_estado == FASE_R) || (r_estado == FASE_G) || (r_estado == FASE_B);
  // Fires on the WD_LIM-th cycle spent in the same phase; the FSM gives flags priority.
  assign w_timeout = w_en_fase && (r_wd == DW'(WD_LIM - 1));

  // Per-phase cycle counter, restarted whenever the state changes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wd <= '0;
    end else if (!w_en_fase || (w_estado_nxt != r_estado)) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Sticky timeout indication, cleared by the next accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_error <= 1'b0;
    end else if ((r_estado == LISTO) && i_iniciar) begin
      r_error <= 1'b0;
    end else if (w_timeout && !i_detener && (w_estado_nxt == LISTO)) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif

  // Next-state, next-count and next-output decode.
  always_comb begin
    w_estado_nxt    = r_estado;
    w_cnt_enter_nxt = r_cnt_enter;
    w_ciclos_r_nxt  = r_ciclos_r;
    w_ciclos_g_nxt  = r_ciclos_g;
    w_ciclos_b_nxt  = r_ciclos_b;
    w_enter_nxt     = 1'b0;
    w_ocupado_nxt   = 1'b0;
    w_led_nxt       = 3'b000;

    case (r_estado)
      CARGA_R: if (i_cargar) begin
        w_ciclos_r_nxt = w_dato_clamp;
        w_estado_nxt   = CARGA_G;
      end
      CARGA_G: if (i_cargar) begin
        w_ciclos_g_nxt = w_dato_clamp;
        w_estado_nxt   = CARGA_B;
      end
      CARGA_B: if (i_cargar) begin
        w_ciclos_b_nxt = w_dato_clamp;
        w_estado_nxt   = LISTO;
      end
      LISTO: begin
        // A start request beats a simultaneous reconfigure request.
        if (i_iniciar) begin
          w_estado_nxt    = ARRANQUE;
          w_cnt_enter_nxt = '0;
        end else if (i_cargar) begin
          w_ciclos_r_nxt = w_dato_clamp;
          w_estado_nxt   = CARGA_R;
        end
      end
      ARRANQUE: begin
        // Flags are deliberately not looked at while enter is being held.
        if (i_detener) begin
          w_estado_nxt = LISTO;
        end else if (r_cnt_enter == ENTER_FIN) begin
          w_estado_nxt = FASE_R;
        end else begin
          w_cnt_enter_nxt = r_cnt_enter + 1'b1;
        end
      end
      FASE_R: begin
        if (i_detener)                w_estado_nxt = LISTO;
        else if (i_flags == 3'b001)   w_estado_nxt = FASE_G;
        else if (w_timeout)           w_estado_nxt = LISTO;
      end
      FASE_G: begin
        if (i_detener)                w_estado_nxt = LISTO;
        else if (i_flags == 3'b010)   w_estado_nxt = FASE_B;
        else if (w_timeout)           w_estado_nxt = LISTO;
      end
      FASE_B: begin
        if (i_detener)                w_estado_nxt = LISTO;
        else if (i_flags == 3'b100)   w_estado_nxt = (REPETIR != 0) ? FASE_R : LISTO;
        else if (w_timeout)           w_estado_nxt = LISTO;
      end
      default: w_estado_nxt = CARGA_R;
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    case (w_estado_nxt)
      ARRANQUE: begin
        w_enter_nxt   = 1'b1;
        w_ocupado_nxt = 1'b1;
      end
      FASE_R: begin
        w_ocupado_nxt = 1'b1;
        w_led_nxt     = 3'b001;
      end
      FASE_G: begin
        w_ocupado_nxt = 1'b1;
        w_led_nxt     = 3'b010;
      end
      FASE_B: begin
        w_ocupado_nxt = 1'b1;
        w_led_nxt     = 3'b100;
      end
      default: begin
        w_ocupado_nxt = 1'b0;
      end
    endcase
  end

  // State, counts and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_estado    <= CARGA_R;
      r_cnt_enter <= '0;
      r_ciclos_r  <= W'(1);
      r_ciclos_g  <= W'(1);
      r_ciclos_b  <= W'(1);
      r_enter     <= 1'b0;
      r_ocupado   <= 1'b0;
      r_led_rgb   <= 3'b000;
    end else begin
      r_estado    <= w_estado_nxt;
      r_cnt_enter <= w_cnt_enter_nxt;
      r_ciclos_r  <= w_ciclos_r_nxt;
      r_ciclos_g  <= w_ciclos_g_nxt;
      r_ciclos_b  <= w_ciclos_b_nxt;
      r_enter     <= w_enter_nxt;
      r_ocupado   <= w_ocupado_nxt;
      r_led_rgb   <= w_led_nxt;
    end
  end

  assign o_ciclos_r = r_ciclos_r;
  assign o_ciclos_g = r_ciclos_g;
  assign o_ciclos_b = r_ciclos_b;
  assign o_enter    = r_enter;
  assign o_ocupado  = r_ocupado;
  assign o_led_rgb  = r_led_rgb;
  assign o_estado   = r_estado;

endmodule

// File: tb/tb_controlador_temporizador.sv
// Testbench for controlador_temporizador: directed scenarios with
// hand-computed expectations. u_dut uses the default REPETIR=1;
// u_dut_p shares the same stimulus with REPETIR=0.
module tb_controlador_temporizador;

  localparam logic [2:0] S_CARGA_R  = 3'd0;
  localparam logic [2:0] S_CARGA_G  = 3'd1;
  localparam logic [2:0] S_LISTO    = 3'd3;
  localparam logic [2:0] S_ARRANQUE = 3'd4;
  localparam logic [2:0] S_FASE_R   = 3'd5;
  localparam logic [2:0] S_FASE_G   = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, cargar, iniciar, detener;
  logic [4:0] dato;
  logic [2:0] flags;

  logic [4:0] ciclos_r, ciclos_g, ciclos_b, p_ciclos_r, p_ciclos_g, p_ciclos_b;
  logic       enter, ocupado, error, p_enter, p_ocupado, p_error;
  logic [2:0] led, estado, p_led, p_estado;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock generation.
  always #5 clk = ~clk;

  controlador_temporizador u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dato(dato), .i_cargar(cargar),
    .i_iniciar(iniciar), .i_detener(detener), .i_flags(flags),
    .o_ciclos_r(ciclos_r), .o_ciclos_g(ciclos_g), .o_ciclos_b(ciclos_b),
    .o_enter(enter), .o_led_rgb(led), .o_ocupado(ocupado), .o_error(error),
    .o_estado(estado)
  );

  controlador_temporizador #(.REPETIR(0)) u_dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_dato(dato), .i_cargar(cargar),
    .i_iniciar(iniciar), .i_detener(detener), .i_flags(flags),
    .o_ciclos_r(p_ciclos_r), .o_ciclos_g(p_ciclos_g), .o_ciclos_b(p_ciclos_b),
    .o_enter(p_enter), .o_led_rgb(p_led), .o_ocupado(p_ocupado), .o_error(p_error),
    .o_estado(p_estado)
  );

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one cargar pulse followed by an idle cycle.
  task automatic load(input logic [4:0] d);
    dato = d; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    tick();
  endtask

  // Driver: one iniciar pulse.
  task automatic start_pulse();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++; if (estado !== S_CARGA_R) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", estado, S_CARGA_R); end
    tests_run++; if ({ciclos_r, ciclos_g, ciclos_b} !== {5'd1, 5'd1, 5'd1}) begin tests_failed++; $display("FAIL reset_ciclos: got %0d/%0d/%0d want 1/1/1", ciclos_r, ciclos_g, ciclos_b); end
    tests_run++; if ({enter, led, ocupado, error} !== 6'b0) begin tests_failed++; $display("FAIL reset_outs: got enter=%b led=%b ocupado=%b error=%b want all 0", enter, led, ocupado, error); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (estado !== S_CARGA_R) begin tests_failed++; $display("FAIL reset_release: got %0d want %0d", estado, S_CARGA_R); end
  endtask

  task automatic test_clamp();
    load(5'd5);
    tests_run++; if (estado !== S_CARGA_G || ciclos_r !== 5'd5) begin tests_failed++; $display("FAIL load_r: got state=%0d R=%0d want state=%0d R=5", estado, ciclos_r, S_CARGA_G); end
    load(5'd0);
    tests_run++; if (ciclos_g !== 5'd1) begin tests_failed++; $display("FAIL clamp_g: got %0d want 1", ciclos_g); end
    load(5'd15);
    tests_run++; if (estado !== S_LISTO) begin tests_failed++; $display("FAIL clamp_listo: got %0d want %0d", estado, S_LISTO); end
  endtask

  task automatic test_reconfig();
    detener = 1'b1;
    tick();
    detener = 1'b0;
    tests_run++; if (estado !== S_LISTO) begin tests_failed++; $display("FAIL detener_listo: got %0d want %0d", estado, S_LISTO); end
    dato = 5'd9; cargar = 1'b1;
    tick();
    cargar = 1'b0;
    tests_run++; if (estado !== S_CARGA_R || ciclos_r !== 5'd9) begin tests_failed++; $display("FAIL reconfig: got state=%0d R=%0d want state=%0d R=9", estado, ciclos_r, S_CARGA_R); end
    load(5'd5); load(5'd10); load(5'd15);
    tests_run++; if ({ciclos_r, ciclos_g, ciclos_b} !== {5'd5, 5'd10, 5'd15}) begin tests_failed++; $display("FAIL load_all: got %0d/%0d/%0d want 5/10/15", ciclos_r, ciclos_g, ciclos_b); end
    tests_run++; if (estado !== S_LISTO) begin tests_failed++; $display("FAIL load_listo: got %0d want %0d", estado, S_LISTO); end
  endtask

  task automatic test_start();
    int n;
    dato = 5'd3; cargar = 1'b1; iniciar = 1'b1;
    tick();
    cargar = 1'b0; iniciar = 1'b0;
    tests_run++; if (estado !== S_ARRANQUE || enter !== 1'b1 || ocupado !== 1'b1) begin tests_failed++; $display("FAIL start_first: got state=%0d enter=%b ocupado=%b want %0d/1/1", estado, enter, ocupado, S_ARRANQUE); end
    tests_run++; if (ciclos_r !== 5'd5) begin tests_failed++; $display("FAIL start_cargar_dropped: got R=%0d want 5", ciclos_r); end
    n = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin flags = 3'b001; cargar = 1'b1; dato = 5'd20; end
      tick();
      flags = 3'b000; cargar = 1'b0;
      if (enter === 1'b1) n++;
      else break;
    end
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL enter_len: got %0d cycles want 10", n); end
    tests_run++; if (estado !== S_FASE_R || led !== 3'b001) begin tests_failed++; $display("FAIL start_fase_r: got state=%0d led=%b want %0d/001", estado, led, S_FASE_R); end
    tests_run++; if (ciclos_r !== 5'd5) begin tests_failed++; $display("FAIL arranque_cargar_ignored: got R=%0d want 5", ciclos_r); end
  endtask

  task automatic test_sequence();
    flags = 3'b010; tick(); flags = 3'b000;
    tests_run++; if (estado !== S_FASE_R) begin tests_failed++; $display("FAIL flag_wrong_bit: got %0d want %0d", estado, S_FASE_R); end
    flags = 3'b011; tick(); flags = 3'b000;
    tests_run++; if (estado !== S_FASE_R || led !== 3'b001) begin tests_failed++; $display("FAIL flag_multi_bit: got state=%0d led=%b want %0d/001", estado, led, S_FASE_R); end
    flags = 3'b001; tick(); flags = 3'b000;
    tests_run++; if (led !== 3'b010 || p_led !== 3'b010) begin tests_failed++; $display("FAIL seq_g: got led=%b p_led=%b want 010/010", led, p_led); end
    flags = 3'b100; tick(); flags = 3'b000;
    tests_run++; if (led !== 3'b010) begin tests_failed++; $display("FAIL seq_g_hold: got %b want 010", led); end
    flags = 3'b010; tick(); flags = 3'b000;
    tests_run++; if (led !== 3'b100) begin tests_failed++; $display("FAIL seq_b: got %b want 100", led); end
    flags = 3'b100; tick(); flags = 3'b000;
    tests_run++; if (led !== 3'b001 || estado !== S_FASE_R || ocupado !== 1'b1 || enter !== 1'b0) begin tests_failed++; $display("FAIL seq_repeat: got led=%b state=%0d ocupado=%b enter=%b want 001/%0d/1/0", led, estado, ocupado, enter, S_FASE_R); end
    tests_run++; if (p_led !== 3'b000 || p_estado !== S_LISTO || p_ocupado !== 1'b0) begin tests_failed++; $display("FAIL seq_single_pass: got led=%b state=%0d ocupado=%b want 000/%0d/0", p_led, p_estado, p_ocupado, S_LISTO); end
  endtask

  task automatic test_detener();
    detener = 1'b1; flags = 3'b001;
    tick();
    detener = 1'b0; flags = 3'b000;
    tests_run++; if (estado !== S_LISTO || led !== 3'b000 || ocupado !== 1'b0) begin tests_failed++; $display("FAIL detener_flag: got state=%0d led=%b ocupado=%b want %0d/000/0", estado, led, ocupado, S_LISTO); end
    tests_run++; if ({ciclos_r, ciclos_g, ciclos_b} !== {5'd5, 5'd10, 5'd15}) begin tests_failed++; $display("FAIL detener_counts: got %0d/%0d/%0d want 5/10/15", ciclos_r, ciclos_g, ciclos_b); end
  endtask

  task automatic test_detener_arranque();
    start_pulse();
    tests_run++; if (p_enter !== 1'b1) begin tests_failed++; $display("FAIL p_start: got enter=%b want 1", p_enter); end
    tick(); tick();
    detener = 1'b1;
    tick();
    detener = 1'b0;
    tests_run++; if (estado !== S_LISTO || enter !== 1'b0 || ocupado !== 1'b0) begin tests_failed++; $display("FAIL detener_arranque: got state=%0d enter=%b ocupado=%b want %0d/0/0", estado, enter, ocupado, S_LISTO); end
    tests_run++; if (p_estado !== S_LISTO || p_enter !== 1'b0) begin tests_failed++; $display("FAIL p_detener_arranque: got state=%0d enter=%b want %0d/0", p_estado, p_enter, S_LISTO); end
  endtask

  task automatic test_watchdog();
    start_pulse();
    for (int i = 0; i < 20 && estado !== S_FASE_R; i++) tick();
    flags = 3'b001; tick(); flags = 3'b000;
    tests_run++; if (estado !== S_FASE_G) begin tests_failed++; $display("FAIL wd_enter_g: got %0d want %0d", estado, S_FASE_G); end
`ifdef WATCHDOG_EN
    for (int i = 0; i < 39; i++) tick();
    tests_run++; if (estado !== S_FASE_G || error !== 1'b0) begin tests_failed++; $display("FAIL wd_before_limit: got state=%0d error=%b want %0d/0", estado, error, S_FASE_G); end
    tick();
    tests_run++; if (estado !== S_LISTO || error !== 1'b1 || led !== 3'b000 || ocupado !== 1'b0) begin tests_failed++; $display("FAIL wd_timeout: got state=%0d error=%b led=%b ocupado=%b want %0d/1/000/0", estado, error, led, ocupado, S_LISTO); end
    start_pulse();
    tests_run++; if (error !== 1'b0 || estado !== S_ARRANQUE) begin tests_failed++; $display("FAIL wd_clear: got error=%b state=%0d want 0/%0d", error, estado, S_ARRANQUE); end
`else
    for (int i = 0; i < 60; i++) tick();
    tests_run++; if (estado !== S_FASE_G || error !== 1'b0 || led !== 3'b010) begin tests_failed++; $display("FAIL no_wd_wait: got state=%0d error=%b led=%b want %0d/0/010", estado, error, led, S_FASE_G); end
`endif
    detener = 1'b1; tick(); detener = 1'b0;
    tests_run++; if (estado !== S_LISTO) begin tests_failed++; $display("FAIL wd_exit: got %0d want %0d", estado, S_LISTO); end
  endtask

  task automatic test_reset_mid();
    start_pulse();
    tick(); tick(); tick();
    tests_run++; if (enter !== 1'b1) begin tests_failed++; $display("FAIL mid_enter_high: got %b want 1", enter); end
    rst_n = 1'b0;
    tick();
    tests_run++; if (enter !== 1'b0 || ocupado !== 1'b0 || estado !== S_CARGA_R || ciclos_r !== 5'd1) begin tests_failed++; $display("FAIL mid_reset: got enter=%b ocupado=%b state=%0d R=%0d want 0/0/%0d/1", enter, ocupado, estado, ciclos_r, S_CARGA_R); end
    rst_n = 1'b1;
    tick();
  endtask

  // Test sequence and final report.
  initial begin
    rst_n = 1'b0; dato = '0; cargar = 1'b0; iniciar = 1'b0; detener = 1'b0; flags = '0;
    test_reset();
    test_clamp();
    test_reconfig();
    test_start();
    test_sequence();
    test_detener();
    test_detener_arranque();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
